rename_map_unit: RTL

Parametrised register-rename stage between the rename queue and the ROB/issue allocation logic. It maps architectural source and destination registers to physical registers using:
- a front-end map table (FRAT),
- a retirement map table (RRAT),
- a circular free list.

It uses a valid/ready handshake on both sides and supports in-order commit. A flush restores the speculative map from the committed state in one cycle.

---
 rtl/rename_map_unit.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rename_map_unit.sv
// Register rename stage: FRAT/RRAT map tables plus a circular free list; optional busy table under RENAME_BUSY_EN.
// Latency: 1 cycle (request accepted at edge N is presented on out_* after edge N).
// Backpressure: output register holds while out_valid && !out_ready; input stalls on full output, empty free list or flush.
module rename_map_unit #(
  parameter int ARCH_BITS = 5,
  parameter int PHYS_BITS = 6,
  parameter int CTRL_W    = 88
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ARCH_BITS-1:0] in_rs,
  input  logic [ARCH_BITS-1:0] in_rt,
  input  logic [ARCH_BITS-1:0] in_rd,
  input  logic                 in_regwrite,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PHYS_BITS-1:0] out_ps,
  output logic [PHYS_BITS-1:0] out_pt,
  output logic [PHYS_BITS-1:0] out_pd,
  output logic [PHYS_BITS-1:0] out_old_pd,
  output logic                 out_alloc,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic                 out_busy_s,
  output logic                 out_busy_t,
  input  logic                 commit_valid,
  input  logic [ARCH_BITS-1:0] commit_rd,
  input  logic [PHYS_BITS-1:0] commit_pd,
  input  logic [PHYS_BITS-1:0] commit_old_pd,
  input  logic                 wb_valid,
  input  logic [PHYS_BITS-1:0] wb_pd,
  input  logic                 flush,
  output logic [PHYS_BITS:0]   free_count
);

  localparam int ARCH     = 1 << ARCH_BITS;
  localparam int PHYS     = 1 << PHYS_BITS;
  localparam int FL_DEPTH = PHYS - ARCH;
  localparam int FLW      = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam int CW       = PHYS_BITS + 1;
  localparam logic [FLW-1:0] FL_LAST = FLW'(FL_DEPTH - 1);
  localparam logic [CW-1:0]  FL_FULL = CW'(FL_DEPTH);

  // Free-list slots are indexed modulo FL_DEPTH, which need not be a power of two.
  function automatic logic [FLW-1:0] f_inc(input logic [FLW-1:0] p);
    return (p == FL_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [PHYS_BITS-1:0] r_frat [ARCH];
  logic [PHYS_BITS-1:0] r_rrat [ARCH];
  logic [PHYS_BITS-1:0] r_list [FL_DEPTH];
  logic [FLW-1:0]       r_head;
  logic [FLW-1:0]       r_tail;
  logic [FLW-1:0]       r_chead;
  logic [CW-1:0]        r_count;

  logic                 r_out_valid;
  logic [PHYS_BITS-1:0] r_out_ps;
  logic [PHYS_BITS-1:0] r_out_pt;
  logic [PHYS_BITS-1:0] r_out_pd;
  logic [PHYS_BITS-1:0] r_out_old_pd;
  logic                 r_out_alloc;
  logic [CTRL_W-1:0]    r_out_ctrl;
  logic                 r_out_busy_s;
  logic                 r_out_busy_t;

  logic                 w_need;
  logic                 w_acc;
  logic                 w_alloc;
  logic [PHYS_BITS-1:0] w_ps;
  logic [PHYS_BITS-1:0] w_pt;
  logic [PHYS_BITS-1:0] w_new_pd;
  logic [PHYS_BITS-1:0] w_prev_pd;
  logic [FLW-1:0]       w_tail_n;
  logic [FLW-1:0]       w_head_f;
  logic [CW-1:0]        w_diff;
  logic [CW-1:0]        w_flush_count;
  logic                 w_busy_s;
  logic                 w_busy_t;

  assign w_need    = in_regwrite && (in_rd != '0);
  assign in_ready  = !flush && (!r_out_valid || out_ready) && (!w_need || (r_count != '0));
  assign w_acc     = in_valid && in_ready;
  assign w_alloc   = w_acc && w_need;

  // Register 0 is hard-zero; its map entry is never written, but the read is forced anyway.
  assign w_ps      = (in_rs == '0) ? '0 : r_frat[in_rs];
  assign w_pt      = (in_rt == '0) ? '0 : r_frat[in_rt];
  assign w_new_pd  = r_list[r_head];
  assign w_prev_pd = r_frat[in_rd];

  // A same-cycle commit is folded in before the flush restore.
  assign w_tail_n  = commit_valid ? f_inc(r_tail)  : r_tail;
  assign w_head_f  = commit_valid ? f_inc(r_chead) : r_chead;

  // Free entries after a flush: distance tail -> head modulo FL_DEPTH, zero meaning a full list.
  always_comb begin
    w_diff = '0;
    if (w_tail_n >= w_head_f) begin
      w_diff = CW'(w_tail_n) - CW'(w_head_f);
    end else begin
      w_diff = CW'(w_tail_n) + FL_FULL - CW'(w_head_f);
    end
    w_flush_count = (w_diff == '0) ? FL_FULL : w_diff;
  end

  // Speculative map: restored from RRAT (plus any same-cycle commit) on flush, else updated on allocation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ARCH; i++) r_frat[i] <= PHYS_BITS'(i);
    end else if (flush) begin
      for (int i = 0; i < ARCH; i++) begin
        if (commit_valid && (i != 0) && (commit_rd == ARCH_BITS'(i))) r_frat[i] <= commit_pd;
        else                                                          r_frat[i] <= r_rrat[i];
      end
    end else if (w_alloc) begin
      r_frat[in_rd] <= w_new_pd;
    end
  end

  // Committed map: updated in program order by retiring instructions.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ARCH; i++) r_rrat[i] <= PHYS_BITS'(i);
    end else if (commit_valid && (commit_rd != '0)) begin
      r_rrat[commit_rd] <= commit_pd;
    end
  end

  // Free-list storage: retiring instructions return their previous mapping at the tail.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < FL_DEPTH; k++) r_list[k] <= PHYS_BITS'(ARCH + k);
    end else if (commit_valid) begin
      r_list[r_tail] <= commit_old_pd;
    end
  end

  // Free-list pointers: head rewinds to the committed head on flush.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_chead <= '0;
    end else begin
      r_tail  <= w_tail_n;
      r_chead <= w_head_f;
      if (flush)        r_head <= w_head_f;
      else if (w_alloc) r_head <= f_inc(r_head);
    end
  end

  // Occupancy: saturates at FL_DEPTH so an illegal extra commit cannot overflow it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_count <= FL_FULL;
    end else if (flush) begin
      r_count <= w_flush_count;
    end else if (w_alloc && !commit_valid) begin
      r_count <= r_count - 1'b1;
    end else if (!w_alloc && commit_valid && (r_count != FL_FULL)) begin
      r_count <= r_count + 1'b1;
    end
  end

`ifdef RENAME_BUSY_EN
  logic [PHYS-1:0] r_busy;

  // A writeback landing on the accept edge already makes the source ready.
  assign w_busy_s = (w_ps != '0) && r_busy[w_ps] && !(wb_valid && (wb_pd == w_ps));
  assign w_busy_t = (w_pt != '0) && r_busy[w_pt] && !(wb_valid && (wb_pd == w_pt));

  // Busy table: set by allocation (wins over a same-edge writeback), cleared by writeback or flush.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      if (wb_valid) r_busy[wb_pd]    <= 1'b0;
      if (w_alloc)  r_busy[w_new_pd] <= 1'b1;
    end
  end
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_valid, wb_pd};
  assign w_busy_s    = 1'b0;
  assign w_busy_t    = 1'b0;
`endif

  // Output register: loads on accept, holds under backpressure, drains when taken, killed by flush.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_out_valid  <= 1'b0;
      r_out_ps     <= '0;
      r_out_pt     <= '0;
      r_out_pd     <= '0;
      r_out_old_pd <= '0;
      r_out_alloc  <= 1'b0;
      r_out_ctrl   <= '0;
      r_out_busy_s <= 1'b0;
      r_out_busy_t <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
    end else if (w_acc) begin
      r_out_valid  <= 1'b1;
      r_out_ps     <= w_ps;
      r_out_pt     <= w_pt;
      r_out_pd     <= w_need ? w_new_pd  : '0;
      r_out_old_pd <= w_need ? w_prev_pd : '0;
      r_out_alloc  <= w_need;
      r_out_ctrl   <= in_ctrl;
      r_out_busy_s <= w_busy_s;
      r_out_busy_t <= w_busy_t;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // Retiring into an already-full free list means the commit stream is out of step with allocation.
  always @(posedge CLK) begin
    if (RESET && commit_valid && (r_count == FL_FULL))
      $display("rename_map_unit: protocol error, commit with full free list at %0t", $time);
  end
`endif

  assign out_valid  = r_out_valid;
  assign out_ps     = r_out_ps;
  assign out_pt     = r_out_pt;
  assign out_pd     = r_out_pd;
  assign out_old_pd = r_out_old_pd;
  assign out_alloc  = r_out_alloc;
  assign out_ctrl   = r_out_ctrl;
  assign out_busy_s = r_out_busy_s;
  assign out_busy_t = r_out_busy_t;
  assign free_count = r_count;

endmodule
